// File: rtl/ctrl_pkg.sv
// Shared types and select encodings for the multicycle ARM main controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    // Arithmetic commands are the only ones that update C and V.
    function automatic logic cmd_is_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational data-processing decode: cmd/S -> ALU operation, flag write enables, NoWrite.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic known;

    always_comb begin
        alu_control = ALU_ADD;
        no_write    = 1'b0;
        known       = 1'b1;
        case (cmd)
            CMD_ADD: alu_control = ALU_ADD;
            CMD_SUB: alu_control = ALU_SUB;
            CMD_AND: alu_control = ALU_AND;
            CMD_ORR: alu_control = ALU_ORR;
            CMD_CMP: begin
                alu_control = ALU_SUB;
                no_write    = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // Unsupported commands still run as ADD but must not disturb the flags.
        flag_w[1] = known & s;
        flag_w[0] = known & s & cmd_is_arith(cmd);
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Moore main controller for the multicycle ARM core (FETCH/DECODE/EXECUTE/MEM/WB sequencing).
// Optional macro CTRL_FSM_BL_EN enables the BL link write (LinkW/RegW in BRANCH).
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       LinkW
);

    localparam int WAIT_W = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_CYCLES);

    statetype          state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              wait_done;
    logic              mem_state;

    logic [1:0] dec_alu_control;
    logic [1:0] dec_flag_w;
    logic       dec_no_write;

    alu_dec u_alu_dec (
        .cmd         (Funct[4:1]),
        .s           (Funct[0]),
        .alu_control (dec_alu_control),
        .flag_w      (dec_flag_w),
        .no_write    (dec_no_write)
    );

    assign mem_state = (state_reg == MEMREAD) || (state_reg == MEMWRITE);
    assign wait_done = (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counter is zero whenever a memory state is entered, since it clears outside them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (mem_state && !wait_done) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    always_comb begin
        state_next = FETCH;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        PCS        = 1'b0;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        LinkW      = 1'b0;

        case (state_reg)
            FETCH: begin
                IRWrite    = 1'b1;
                NextPC     = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_B:    state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                state_next = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = wait_done ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                RegW       = 1'b1;
                PCS        = (Rd == 4'd15);
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemW       = wait_done;
                state_next = wait_done ? FETCH : MEMWRITE;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcB    = (state_reg == EXECUTEI) ? SRCB_IMM : SRCB_WD;
                ALUControl = dec_alu_control;
                FlagW      = dec_flag_w;
                NoWrite    = dec_no_write;
                state_next = ALUWB;
            end
            ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegW       = 1'b1;
                ALUControl = dec_alu_control;
                NoWrite    = dec_no_write;
                PCS        = (Rd == 4'd15) && !dec_no_write;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                PCS        = 1'b1;
`ifdef CTRL_FSM_BL_EN
                if (Funct[4]) begin
                    LinkW = 1'b1;
                    RegW  = 1'b1;
                end
`endif
                state_next = FETCH;
            end
            default: begin
                // UNKNOWN and illegal encodings: a NOP that returns to FETCH.
                state_next = FETCH;
            end
        endcase
    end

endmodule
